// File: rtl/mult_div_unit.sv
// Multicycle 32-bit multiply/divide unit: radix-2 Booth multiply and restoring divide, one bit per clock.
// Optional MDU_UNSIGNED_EN enables multu/divu semantics through is_unsigned.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic        is_unsigned,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [33:0] acc_q, acc_d;
    logic [33:0] mcand_q, mcand_d;
    logic [31:0] mq_q, mq_d;
    logic        qm1_q, qm1_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        uns_q, uns_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic        start_uns;
    logic [33:0] booth_sum;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

`ifdef MDU_UNSIGNED_EN
    assign start_uns = is_unsigned;
`else
    logic unused_is_unsigned;
    assign unused_is_unsigned = is_unsigned;
    assign start_uns = 1'b0;
`endif

    assign a_mag = (start_uns || !A[31]) ? A : -A;
    assign b_mag = (start_uns || !B[31]) ? B : -B;

    // Divisor <= 2^32-1 and remainder < divisor, so bit 32 of the difference is a reliable borrow.
    assign rem_shift = {rem_q, mq_q[31]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};
    assign quo_next  = {mq_q[30:0], ~rem_diff[32]};
    assign rem_next  = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];

    always_comb begin
        booth_sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        uns_d     = uns_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    mcand_d = start_uns ? {2'b00, A} : {{2{A[31]}}, A};
                    acc_d   = '0;
                    mq_d    = B;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    uns_d   = start_uns;
                    dz_d    = 1'b0;
                    state_d = MULT;
                end else if (start_div) begin
                    uns_d = start_uns;
                    if (B == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d      = 1'b0;
                        cnt_d     = '0;
                        rem_d     = '0;
                        mq_d      = a_mag;
                        dvsr_d    = b_mag;
                        quo_neg_d = !start_uns && (A[31] ^ B[31]);
                        rem_neg_d = !start_uns && A[31];
                        state_d   = DIV;
                    end
                end
            end
            MULT: begin
                acc_d = {booth_sum[33], booth_sum[33:1]};
                mq_d  = {booth_sum[0], mq_q[31:1]};
                qm1_d = mq_q[0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    // Booth treats the multiplier as signed; unsigned needs M*2^32 added back when its MSB was set.
                    hi_d    = acc_d[31:0] + ((uns_q && qm1_d) ? mcand_q[31:0] : 32'd0);
                    lo_d    = mq_d;
                    state_d = DONE;
                end
            end
            DIV: begin
                mq_d  = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    lo_d    = quo_neg_q ? -quo_next : quo_next;
                    hi_d    = rem_neg_q ? -rem_next : rem_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == MULT) || (state_d == DIV);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mq_q      <= '0;
            qm1_q     <= 1'b0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            uns_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mq_q      <= mq_d;
            qm1_q     <= qm1_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            uns_q     <= uns_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero/latency, a monitor checks on done.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic        is_unsigned;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_zero;

    always #5 clock = ~clock;

    mult_div_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .is_unsigned (is_unsigned),
        .A           (A),
        .B           (B),
        .HI          (HI),
        .LO          (LO),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] dz;
        int          done_cyc;
        int          busy_n;
    } exp_t;

    exp_t        sb[$];
    int          tests  = 0;
    int          failed = 0;
    int          cyc    = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input bit do_mult, input logic [31:0] a, input logic [31:0] b,
                                   input bit uns, input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                                   input int now);
        exp_t             e;
        bit               u;
        logic signed [63:0] sa, sb_v, p;
        logic [63:0]      up;
        int               ia, ib;
`ifdef MDU_UNSIGNED_EN
        u = uns;
`else
        u = 1'b0;
`endif
        e.dz       = 32'd0;
        e.done_cyc = now + 33;
        e.busy_n   = 32;
        if (do_mult) begin
            if (u) begin
                up   = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end else begin
                sa   = $signed(a);
                sb_v = $signed(b);
                p    = sa * sb_v;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
        end else if (b == 32'd0) begin
            e.hi       = prev_hi;
            e.lo       = prev_lo;
            e.dz       = 32'd1;
            e.done_cyc = now + 1;
            e.busy_n   = 0;
        end else if (u) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
        end else begin
            ia   = a;
            ib   = b;
            e.lo = ia / ib;
            e.hi = ia % ib;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        int   busy_run;
        busy_run = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (done) begin
                    if (sb.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL unexpected_done: done=1 with nothing pending, expected done=0");
                    end else begin
                        e = sb.pop_front();
                        chk("HI", HI, e.hi);
                        chk("LO", LO, e.lo);
                        chk("div_zero", {31'd0, div_zero}, e.dz);
                        chk("latency_cycle", cyc, e.done_cyc);
                        chk("busy_cycles", busy_run, e.busy_n);
                        $display("[TB] done: HI=%h LO=%h div_zero=%0d busy_cycles=%0d", HI, LO, div_zero, busy_run);
                    end
                    busy_run = 0;
                end
            end
        end
    end

    task automatic issue(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b, input bit uns);
        exp_t e;
        @(negedge clock);
        #1;
        e = model(sm, a, b, uns, m_hi, m_lo, cyc);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        $display("[TB] issue %s a=%h b=%h uns=%0d", sm ? "mult" : "div", a, b, uns);
        start_mult  = sm;
        start_div   = sd;
        A           = a;
        B           = b;
        is_unsigned = uns;
        @(negedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input bit sm, input logic [31:0] a, input logic [31:0] b, input bit uns);
        issue(sm, !sm, a, b, uns);
        wait_empty();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        reset       = 1'b1;
        start_mult  = 1'b0;
        start_div   = 1'b0;
        is_unsigned = 1'b0;
        A           = '0;
        B           = '0;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_div_zero", {31'd0, div_zero}, 32'd0);

        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // HI=0x12, LO=0x34, then divide by zero must leave them untouched
        run_op(1'b0, 32'h692, 32'h20, 1'b0);
        run_op(1'b0, 32'd5, 32'd0, 1'b0);
        chk("div_zero_sticky", {31'd0, div_zero}, 32'd1);
        run_op(1'b1, 32'd3, 32'd5, 1'b0);

        // start_div during a multiply is ignored
        issue(1'b1, 1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
        repeat (5) @(negedge clock);
        #1;
        start_div = 1'b1;
        A         = 32'd9;
        B         = 32'd0;
        @(negedge clock);
        #1;
        start_div = 1'b0;
        wait_empty();
        @(negedge clock);
        #1;

        // simultaneous starts: multiply wins
        run_op(1'b1, 32'd100, 32'd7, 1'b0);
        issue(1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
        wait_empty();
        @(negedge clock);
        #1;

        // start pulse during the DONE cycle is dropped
        issue(1'b1, 1'b0, 32'd11, 32'd13, 1'b0);
        wait_empty();
        start_mult = 1'b1;
        A          = 32'd99;
        B          = 32'd99;
        @(negedge clock);
        #1;
        start_mult = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        chk("done_cycle_start_busy", {31'd0, busy}, 32'd0);
        chk("done_cycle_start_HI", HI, m_hi);
        chk("done_cycle_start_LO", LO, m_lo);

        // asynchronous reset in the middle of a multiply
        issue(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        repeat (9) @(negedge clock);
        #1;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_HI", HI, 32'd0);
        chk("async_reset_LO", LO, 32'd0);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_done", {31'd0, done}, 32'd0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
